// File: rtl/mode_led_indicator_if.sv
// Mode request / LED status bundle for mode_led_indicator.
// Led_duty is present only when LED_PWM_EN is defined.
interface mode_led_indicator_if #(
    parameter int unsigned NUM_MODES = 5,
    parameter int unsigned MODE_W    = 3
);
    logic [MODE_W-1:0]    Mode;
    logic [NUM_MODES-1:0] Led_Mode;
    logic                 Busy;
    logic                 Mode_err;
`ifdef LED_PWM_EN
    logic [7:0]           Led_duty;

    modport master (output Mode, output Led_duty, input Led_Mode, input Busy, input Mode_err);
    modport slave  (input Mode, input Led_duty, output Led_Mode, output Busy, output Mode_err);
`else
    modport master (output Mode, input Led_Mode, input Busy, input Mode_err);
    modport slave  (input Mode, output Led_Mode, output Busy, output Mode_err);
`endif
endinterface

// File: rtl/mode_led_indicator.sv
// Front-panel mode indicator: one-hot LED drive that blinks the new mode on every change.
// Define LED_PWM_EN to add Led_duty brightness control through a free-running 8-bit PWM.
module mode_led_indicator #(
    parameter int unsigned NUM_MODES   = 5,
    parameter int unsigned MODE_W      = 3,
    parameter int unsigned BLINK_DIV   = 4,
    parameter int unsigned BLINK_COUNT = 2
) (
    input  logic                Fg_clk,
    input  logic                Reset,
    mode_led_indicator_if.slave mode_if
);
    localparam int unsigned      DIV_W     = $clog2(BLINK_DIV) + 1;
    localparam int unsigned      BLK_W     = $clog2(BLINK_COUNT + 1) + 1;
    localparam logic [MODE_W:0]  NUM_M     = (MODE_W + 1)'(NUM_MODES);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BLINK_DIV - 1);
    localparam logic [BLK_W-1:0] BLINK_TOT = BLK_W'(BLINK_COUNT);

    typedef enum logic [1:0] {STEADY, BLK_OFF, BLK_ON} state_t;

    state_t               r_state, w_state_nxt;
    logic [MODE_W-1:0]    r_cur_mode, w_cur_nxt, w_eff_mode;
    logic [DIV_W-1:0]     r_div_cnt, w_div_nxt;
    logic [BLK_W-1:0]     r_blink_cnt, w_blink_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_err;
    logic [NUM_MODES-1:0] r_led, w_led_nxt, w_led_drv;
    logic                 w_mode_bad;

    assign w_mode_bad = ({1'b0, mode_if.Mode} >= NUM_M);
    assign w_eff_mode = w_mode_bad ? '0 : mode_if.Mode;

    // A mode change takes priority over phase timing and restarts the sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur_mode;
        w_div_nxt   = r_div_cnt;
        w_blink_nxt = r_blink_cnt;
        w_busy_nxt  = r_busy;
        if (w_eff_mode != r_cur_mode) begin
            w_cur_nxt = w_eff_mode;
            if (BLINK_COUNT != 0) begin
                w_state_nxt = BLK_OFF;
                w_div_nxt   = '0;
                w_blink_nxt = '0;
                w_busy_nxt  = 1'b1;
            end
        end else begin
            case (r_state)
                BLK_OFF: begin
                    if (r_div_cnt == DIV_LAST) begin
                        w_state_nxt = BLK_ON;
                        w_div_nxt   = '0;
                    end else begin
                        w_div_nxt = r_div_cnt + 1'b1;
                    end
                end
                BLK_ON: begin
                    if (r_div_cnt == DIV_LAST) begin
                        w_div_nxt   = '0;
                        w_blink_nxt = r_blink_cnt + 1'b1;
                        if (w_blink_nxt == BLINK_TOT) begin
                            w_state_nxt = STEADY;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_state_nxt = BLK_OFF;
                        end
                    end else begin
                        w_div_nxt = r_div_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // LED level follows the next phase: dark only while heading into BLK_OFF.
        w_led_nxt = (w_state_nxt == BLK_OFF) ? '0 : (NUM_MODES'(1) << w_cur_nxt);
    end

`ifdef LED_PWM_EN
    logic [7:0] r_pwm_cnt;
    logic       w_pwm_on;

    assign w_pwm_on  = (r_pwm_cnt < mode_if.Led_duty);
    assign w_led_drv = w_pwm_on ? w_led_nxt : '0;

    always_ff @(posedge Fg_clk) begin
        if (Reset) r_pwm_cnt <= '0;
        else       r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
`else
    assign w_led_drv = w_led_nxt;
`endif

    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            r_state     <= STEADY;
            r_cur_mode  <= '0;
            r_div_cnt   <= '0;
            r_blink_cnt <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_led       <= NUM_MODES'(1);
        end else begin
            r_state     <= w_state_nxt;
            r_cur_mode  <= w_cur_nxt;
            r_div_cnt   <= w_div_nxt;
            r_blink_cnt <= w_blink_nxt;
            r_busy      <= w_busy_nxt;
            r_err       <= w_mode_bad;
            r_led       <= w_led_drv;
        end
    end

    assign mode_if.Led_Mode = r_led;
    assign mode_if.Busy     = r_busy;
    assign mode_if.Mode_err = r_err;
endmodule

// File: tb/tb_mode_led_indicator.sv
// Scoreboard bench for mode_led_indicator: a blinking instance and a BLINK_COUNT=0 instance.
// Define LED_PWM_EN on both RTL and bench to exercise the PWM variant.
module tb_mode_led_indicator;
    localparam int unsigned NM  = 5;
    localparam int unsigned MW  = 3;
    localparam int unsigned DIV = 4;

    typedef struct packed { logic [4:0] led; logic busy; logic err; } obs_t;
    typedef struct packed { obs_t a; obs_t b; } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mode_led_indicator_if #(.NUM_MODES(NM), .MODE_W(MW)) if_a ();
    mode_led_indicator_if #(.NUM_MODES(NM), .MODE_W(MW)) if_b ();

    mode_led_indicator #(.NUM_MODES(NM), .MODE_W(MW), .BLINK_DIV(DIV), .BLINK_COUNT(2)) dut_a (
        .Fg_clk(clk), .Reset(rst), .mode_if(if_a.slave));
    mode_led_indicator #(.NUM_MODES(NM), .MODE_W(MW), .BLINK_DIV(DIV), .BLINK_COUNT(0)) dut_b (
        .Fg_clk(clk), .Reset(rst), .mode_if(if_b.slave));

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    obs_t obs_a, obs_b;

    int   m_cur[2];
    int   m_pos[2];
    bit   m_act[2];
    int   bc[2]   = '{2, 0};
    int   m_pwm   = 0;
    int   duty    = 255;
    bit   last_on = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural reference: position counter since the change edge, LED dark on even DIV slots.
    task automatic model_edge(input int mode, input bit r, output exp_t e);
        obs_t o[2];
        bit   on;
        on = 1'b1;
`ifdef LED_PWM_EN
        on = r || (m_pwm < duty);
        m_pwm = r ? 0 : (m_pwm + 1) % 256;
`endif
        last_on = on;
        for (int i = 0; i < 2; i++) begin
            int eff;
            if (r) begin
                m_cur[i] = 0; m_act[i] = 1'b0; m_pos[i] = 0; o[i].err = 1'b0;
            end else begin
                eff = (mode < NM) ? mode : 0;
                if (eff != m_cur[i]) begin
                    m_cur[i] = eff; m_act[i] = (bc[i] > 0); m_pos[i] = 0;
                end else if (m_act[i]) begin
                    m_pos[i]++;
                    if (m_pos[i] == 2 * bc[i] * DIV) m_act[i] = 1'b0;
                end
                o[i].err = (mode >= NM);
            end
            o[i].busy = m_act[i];
            o[i].led  = (m_act[i] && ((m_pos[i] / DIV) % 2 == 0)) ? 5'b0 : (5'b1 << m_cur[i]);
            if (!on) o[i].led = 5'b0;
        end
        e.a = o[0];
        e.b = o[1];
    endtask

    function automatic logic [4:0] lit(input logic [4:0] x);
        return last_on ? x : 5'b0;
    endfunction

    task automatic step(input int mode, input bit r);
        exp_t e;
        @(negedge clk);
        rst = r;
        if_a.Mode = MW'(mode);
        if_b.Mode = MW'(mode);
`ifdef LED_PWM_EN
        if_a.Led_duty = 8'(duty);
        if_b.Led_duty = 8'(duty);
`endif
        model_edge(mode, r, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs_a = '{if_a.Led_Mode, if_a.Busy, if_a.Mode_err};
        obs_b = '{if_b.Led_Mode, if_b.Busy, if_b.Mode_err};
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("sb_a", obs_a, e.a);
            check_eq("sb_b", obs_b, e.b);
        end
    endtask

    initial begin
        int cnt;
        int rm;
        rst = 1'b1;
        if_a.Mode = '0;
        if_b.Mode = '0;
`ifdef LED_PWM_EN
        if_a.Led_duty = 8'd255;
        if_b.Led_duty = 8'd255;
`endif
        // Reset held with Mode=3
        for (int k = 0; k < 3; k++) begin
            step(3, 1'b1);
            check_eq("rst_led", obs_a.led, 5'b00001);
            check_eq("rst_busy", obs_a.busy, 0);
            check_eq("rst_err", obs_a.err, 0);
        end
        step(0, 1'b0);
        step(0, 1'b0);
        check_eq("idle_busy", obs_a.busy, 0);

        // Change 0->2: full blink sequence
        for (int k = 0; k <= 16; k++) begin
            logic [4:0] el;
            step(2, 1'b0);
            el = (k < 4 || (k >= 8 && k < 12)) ? 5'b0 : 5'b00100;
            check_eq("chg_led", obs_a.led, lit(el));
            check_eq("chg_busy", obs_a.busy, (k < 16) ? 1 : 0);
        end
        check_eq("chg_err", obs_a.err, 0);

        // Restart mid-sequence: 2->1, then 4 at k=5
        for (int k = 0; k <= 22; k++) begin
            step((k < 5) ? 1 : 4, 1'b0);
            if (k == 5) begin
                check_eq("rs_led5", obs_a.led, 5'b0);
                check_eq("rs_busy5", obs_a.busy, 1);
            end
            if (k == 8)  check_eq("rs_led8", obs_a.led, 5'b0);
            if (k == 9)  check_eq("rs_led9", obs_a.led, lit(5'b10000));
            if (k == 20) check_eq("rs_busy20", obs_a.busy, 1);
            if (k == 21) begin
                check_eq("rs_busy21", obs_a.busy, 0);
                check_eq("rs_led21", obs_a.led, lit(5'b10000));
            end
        end

        // Invalid code from cur_mode=3
        for (int k = 0; k <= 16; k++) step(3, 1'b0);
        check_eq("inv_pre_led", obs_a.led, lit(5'b01000));
        step(7, 1'b0);
        check_eq("inv_err", obs_a.err, 1);
        check_eq("inv_busy", obs_a.busy, 1);
        check_eq("inv_led", obs_a.led, 5'b0);
        check_eq("inv_b_led", obs_b.led, lit(5'b00001));
        for (int k = 1; k <= 16; k++) step(7, 1'b0);
        check_eq("inv_end_led", obs_a.led, lit(5'b00001));
        check_eq("inv_end_busy", obs_a.busy, 0);
        step(6, 1'b0);
        check_eq("inv6_err", obs_a.err, 1);
        check_eq("inv6_busy", obs_a.busy, 0);
        check_eq("inv6_led", obs_a.led, lit(5'b00001));

        // No-blink instance: 1->3 in one edge
        step(1, 1'b0);
        step(1, 1'b0);
        check_eq("nb_led1", obs_b.led, lit(5'b00010));
        step(3, 1'b0);
        check_eq("nb_led3", obs_b.led, lit(5'b01000));
        check_eq("nb_busy", obs_b.busy, 0);
        check_eq("nb_a_busy", obs_a.busy, 1);
        for (int k = 0; k < 17; k++) step(3, 1'b0);

        // Reset mid-sequence
        step(2, 1'b0);
        for (int k = 0; k < 5; k++) step(2, 1'b0);
        step(2, 1'b1);
        check_eq("rm_led", obs_a.led, 5'b00001);
        check_eq("rm_busy", obs_a.busy, 0);
        step(0, 1'b0);
        check_eq("rm_post_led", obs_a.led, lit(5'b00001));
        check_eq("rm_post_busy", obs_a.busy, 0);

`ifdef LED_PWM_EN
        duty = 64;
        cnt  = 0;
        for (int k = 0; k < 256; k++) begin
            step(0, 1'b0);
            cnt += int'(obs_a.led[0]);
        end
        check_eq("pwm64_on", cnt, 64);
        duty = 0;
        cnt  = 0;
        for (int k = 0; k < 256; k++) begin
            step(0, 1'b0);
            cnt += int'(obs_a.led[0]);
        end
        check_eq("pwm0_on", cnt, 0);
        duty = 255;
`endif

        // Random mode changes with occasional reset
        rm = 0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0) rm = $urandom_range(0, 7);
            step(rm, ($urandom_range(0, 63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
